// File: rtl/accel_pkg.sv
// Shared constants and types for the ADXL362 SPI reader.
//   - SPI command/register bytes used by the configuration write and the
//     burst read
//   - FSM state encodings for the top level and for the shift engine
//   - to_offset_bin(): converts a 12-bit two's complement sample to the
//     9-bit offset-binary format used downstream
package accel_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

  localparam logic [8:0] ZERO_G = 9'h100;

  localparam logic [5:0] CFG_BITS  = 6'd24;
  localparam logic [5:0] READ_BITS = 6'd48;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_CFG,
    ST_IDLE,
    ST_READ,
    ST_UPDATE
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_LOW,
    PH_HIGH,
    PH_TAIL,
    PH_GAP
  } phase_t;

  // Sample is d = {h[3:0], l[7:0]}; keep the top 9 bits and flip the sign
  // bit so that 0 g lands on 9'h100. Only the bits that matter are passed.
  function automatic logic [8:0] to_offset_bin(input logic [3:0] h,
                                               input logic [7:3] l);
    return {~h[3], h[2:0], l[7:3]};
  endfunction

endpackage

// File: rtl/accel_spi_shifter.sv
// Generic mode-0 SPI shift engine, up to 48 bits per transaction, MSB first.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_start          begin a transaction (accepted only when not busy)
//   i_len            number of bits (1..48)
//   i_tx_data        transmit word, left-aligned (bit 47 goes out first)
//   o_busy           high from start until the post-transaction gap ends
//   o_done           one-cycle pulse, coincident with cs_n returning high
//   o_rx_data        received bits, right-aligned (last bit in bit 0)
//   o_sclk/o_mosi/o_cs_n/i_miso  SPI pins
// Framing: CLK_DIV cycles of setup after cs_n falls, 2*CLK_DIV cycles per
// bit (low then high), CLK_DIV cycles of hold before cs_n rises, and at
// least CLK_DIV cycles with cs_n high before the next start is accepted.
module accel_spi_shifter
  import accel_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [5:0]  i_len,
  input  logic [47:0] i_tx_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [47:0] o_rx_data,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_cs_n,
  input  logic        i_miso
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);

  phase_t        r_phase, w_phase_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]    r_bits, w_bits_nxt;
  logic [47:0]   r_tx, w_tx_nxt;
  logic [47:0]   r_rx, w_rx_nxt;
  logic          r_sclk, w_sclk_nxt;
  logic          r_mosi, w_mosi_nxt;
  logic          r_cs_n, w_cs_n_nxt;
  logic          r_done, w_done_nxt;
  logic          r_miso_s1, r_miso_s2;
  logic          w_tc;

  assign w_tc = (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_phase   <= PH_IDLE;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_done    <= 1'b0;
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bits    <= w_bits_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_done    <= w_done_nxt;
      r_miso_s1 <= i_miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_bits_nxt  = r_bits;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_cs_n_nxt  = r_cs_n;
    w_done_nxt  = 1'b0;
    case (r_phase)
      PH_IDLE: begin
        if (i_start && (i_len != 6'd0)) begin
          w_phase_nxt = PH_LOW;
          w_cnt_nxt   = DIV_M1;
          w_bits_nxt  = i_len;
          w_tx_nxt    = i_tx_data;
          w_rx_nxt    = '0;
          w_mosi_nxt  = i_tx_data[47];
          w_cs_n_nxt  = 1'b0;
        end
      end
      PH_LOW: begin
        if (w_tc) begin
          w_sclk_nxt  = 1'b1;
          w_cnt_nxt   = DIV_M1;
          w_phase_nxt = PH_HIGH;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      PH_HIGH: begin
        // The synchronizer output lags the pin by two cycles, so taking it
        // on the first high cycle reflects miso as it stood just before the
        // rising edge, well after the sensor's falling-edge update.
        if (r_cnt == DIV_M1) begin
          w_rx_nxt = {r_rx[46:0], r_miso_s2};
        end
        if (w_tc) begin
          w_sclk_nxt = 1'b0;
          w_cnt_nxt  = DIV_M1;
          if (r_bits == 6'd1) begin
            w_bits_nxt  = 6'd0;
            w_mosi_nxt  = 1'b0;
            w_phase_nxt = PH_TAIL;
          end else begin
            w_bits_nxt  = r_bits - 6'd1;
            w_tx_nxt    = {r_tx[46:0], 1'b0};
            w_mosi_nxt  = r_tx[46];
            w_phase_nxt = PH_LOW;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      PH_TAIL: begin
        if (w_tc) begin
          w_cs_n_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = DIV_M1;
          w_phase_nxt = PH_GAP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      PH_GAP: begin
        if (w_tc) begin
          w_phase_nxt = PH_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_phase_nxt = PH_IDLE;
    endcase
  end

  assign o_busy    = (r_phase != PH_IDLE);
  assign o_done    = r_done;
  assign o_rx_data = r_rx;
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_cs_n    = r_cs_n;

endmodule

// File: rtl/accel_spi_reader.sv
// ADXL362 reader: waits out sensor power-up, writes POWER_CTL for
// measurement mode, then burst-reads X/Y every SAMPLE_PERIOD cycles and
// presents them as 9-bit offset-binary samples with a one-cycle strobe.
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_miso                SPI data from the sensor
//   o_sclk, o_mosi, o_cs_n  SPI master pins (mode 0)
//   o_accel_x_out/_y_out  latest samples, 9'h100 = 0 g
//   o_data_valid          one-cycle pulse when the samples update
//   o_config_done         high after the POWER_CTL write, until reset
module accel_spi_reader
  import accel_pkg::*;
#(
  parameter int CLK_DIV        = 50,
  parameter int SAMPLE_PERIOD  = 1_000_000,
  parameter int POWERUP_CYCLES = 600_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic [8:0] o_accel_x_out,
  output logic [8:0] o_accel_y_out,
  output logic       o_data_valid,
  output logic       o_config_done
);

  localparam int PW = $clog2(POWERUP_CYCLES + 1);
  localparam int SW = $clog2(SAMPLE_PERIOD + 1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pwr_cnt;
  logic [SW-1:0] r_tmr;
  logic          r_pend;
  logic          r_launched;
  logic          r_cfg_done;
  logic [8:0]    r_x, r_y;

  logic          w_tick;
  logic          w_consume;
  logic          w_start;
  logic [5:0]    w_len;
  logic [47:0]   w_tx;
  logic          w_busy;
  logic          w_done;
  logic [47:0]   w_rx;
  logic          w_unused_rx;

  accel_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_start),
    .i_len     (w_len),
    .i_tx_data (w_tx),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_rx_data (w_rx),
    .o_sclk    (o_sclk),
    .o_mosi    (o_mosi),
    .o_cs_n    (o_cs_n),
    .i_miso    (i_miso)
  );

  assign w_tick = r_cfg_done && (r_tmr == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_consume   = 1'b0;
    w_len       = READ_BITS;
    w_tx        = {CMD_READ, REG_XDATA_L, 32'h0};
    case (r_state)
      ST_PWRUP: begin
        if (r_pwr_cnt == '0) w_state_nxt = ST_CFG;
      end
      ST_CFG: begin
        w_len   = CFG_BITS;
        w_tx    = {CMD_WRITE, REG_POWER_CTL, PWR_MEASURE, 24'h0};
        w_start = !r_launched && !w_busy;
        if (r_launched && w_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_tick || r_pend) begin
          w_state_nxt = ST_READ;
          w_consume   = 1'b1;
        end
      end
      ST_READ: begin
        // Waits out the shifter's cs_n-high gap before relaunching.
        w_start = !r_launched && !w_busy;
        if (r_launched && w_done) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        // A tick seen during the read goes straight into the next read.
        if (w_tick || r_pend) begin
          w_state_nxt = ST_READ;
          w_consume   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_PWRUP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_PWRUP;
      r_pwr_cnt  <= PW'(POWERUP_CYCLES - 1);
      r_tmr      <= SW'(SAMPLE_PERIOD - 1);
      r_pend     <= 1'b0;
      r_launched <= 1'b0;
      r_cfg_done <= 1'b0;
      r_x        <= ZERO_G;
      r_y        <= ZERO_G;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == ST_PWRUP) && (r_pwr_cnt != '0)) begin
        r_pwr_cnt <= r_pwr_cnt - PW'(1);
      end

      if (!r_cfg_done || (r_tmr == '0)) begin
        r_tmr <= SW'(SAMPLE_PERIOD - 1);
      end else begin
        r_tmr <= r_tmr - SW'(1);
      end

      if (w_consume) begin
        r_pend <= 1'b0;
      end else if (w_tick) begin
        r_pend <= 1'b1;
      end

      if (w_start) begin
        r_launched <= 1'b1;
      end else if (w_state_nxt != r_state) begin
        r_launched <= 1'b0;
      end

      if ((r_state == ST_CFG) && (w_state_nxt == ST_IDLE)) begin
        r_cfg_done <= 1'b1;
      end

      // Received bytes: [31:24]=XL [23:16]=XH [15:8]=YL [7:0]=YH.
      if ((r_state == ST_READ) && (w_state_nxt == ST_UPDATE)) begin
        r_x <= to_offset_bin(w_rx[19:16], w_rx[31:27]);
        r_y <= to_offset_bin(w_rx[3:0], w_rx[15:11]);
      end
    end
  end

  // Command echo, high nibbles and low fraction bits are not part of the
  // 9-bit sample.
  assign w_unused_rx = ^{w_rx[47:32], w_rx[26:20], w_rx[10:4]};

  assign o_accel_x_out = r_x;
  assign o_accel_y_out = r_y;
  assign o_data_valid  = (r_state == ST_UPDATE);
  assign o_config_done = r_cfg_done;

endmodule

// File: tb/tb_accel_spi_reader.sv
module tb_accel_spi_reader;

  localparam int CLK_DIV = 2;
  localparam int SP      = 50;
  localparam int PU      = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       miso;
  logic       sclk, mosi, cs_n;
  logic [8:0] ax, ay;
  logic       dv, cfg;

  always #5 clk = ~clk;

  accel_spi_reader #(
    .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .POWERUP_CYCLES(PU)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_miso(miso),
    .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n),
    .o_accel_x_out(ax), .o_accel_y_out(ay),
    .o_data_valid(dv), .o_config_done(cfg)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- sensor model (mode 0, MSB first) ----------------
  logic [47:0] resp = '0;
  logic [47:0] m_sh = '0;
  logic [47:0] m_rx = '0;
  logic [47:0] last_rx = '0;
  int          m_bits = 0;
  int          last_bits = 0;
  int          n_reads48 = 0;
  logic        p_cs = 1'b1;
  logic        p_sclk = 1'b0;

  assign miso = m_sh[47];

  always @(cs_n or sclk) begin
    if (p_cs === 1'b1 && cs_n === 1'b0) begin
      m_bits = 0;
      m_rx   = '0;
      m_sh   = resp;
    end else if (p_cs === 1'b0 && cs_n === 1'b1) begin
      last_rx   = m_rx;
      last_bits = m_bits;
      if (m_bits == 48) n_reads48++;
    end
    if (cs_n === 1'b0 && p_sclk === 1'b0 && sclk === 1'b1) begin
      m_rx = {m_rx[46:0], mosi};
      m_bits++;
    end
    if (cs_n === 1'b0 && p_sclk === 1'b1 && sclk === 1'b0) begin
      m_sh = {m_sh[46:0], 1'b0};
    end
    p_cs   = cs_n;
    p_sclk = sclk;
  end

  // ---------------- pin / strobe monitor ----------------
  int   cyc = 0;
  always @(posedge clk) cyc++;

  logic q_cs = 1'b1, q_sclk = 1'b0, q_mosi = 1'b0, q_dv = 1'b0;
  logic [8:0] q_x = 9'h100, q_y = 9'h100;
  int   t_fall = 0, t_sfall = 0, t_rise = -1, t_dv = -1;
  logic rise_pend = 1'b0;
  int   lead = -1, tail = -1, min_gap = 1000000;
  int   mosi_viol = 0, dv_double = 0, chg_viol = 0, pair_err = 0, n_dv = 0;
  int   iv = 0, iv_min = 1000000, iv_max = 0;
  logic iv_en = 1'b0;

  always @(negedge clk) begin
    if (q_cs && !cs_n) begin
      if (t_rise >= 0 && (cyc - t_rise) < min_gap) min_gap = cyc - t_rise;
      t_fall    = cyc;
      rise_pend = 1'b1;
    end
    if (!q_sclk && sclk && rise_pend) begin
      lead      = cyc - t_fall;
      rise_pend = 1'b0;
    end
    if (q_sclk && !sclk) t_sfall = cyc;
    if (!q_cs && cs_n) begin
      tail   = cyc - t_sfall;
      t_rise = cyc;
    end
    if (q_sclk && sclk && (mosi !== q_mosi)) mosi_viol++;
    if (dv && q_dv) dv_double++;
    if (!rst && !dv && ((ax !== q_x) || (ay !== q_y))) chg_viol++;
    if (dv === 1'b1) begin
      if (n_reads48 != n_dv + 1) pair_err++;
      n_dv++;
      if (iv_en && t_dv >= 0) begin
        iv = cyc - t_dv;
        if (iv < iv_min) iv_min = iv;
        if (iv > iv_max) iv_max = iv;
      end
      t_dv = cyc;
    end
    q_cs = cs_n; q_sclk = sclk; q_mosi = mosi; q_dv = dv; q_x = ax; q_y = ay;
  end

  // ---------------- helpers ----------------
  task automatic measure_pwrup(output int c);
    logic found;
    found = 1'b0;
    c = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (cs_n === 1'b0) found = 1'b1;
    end
  endtask

  task automatic wait_cs_rise(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (cs_n === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_dv(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (dv === 1'b1) ok = 1'b1;
    end
  endtask

  // ---------------- directed sequence ----------------
  int   c;
  logic ok;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 48'(cs_n), 48'd1);
    chk("rst_sclk", 48'(sclk), 48'd0);
    chk("rst_mosi", 48'(mosi), 48'd0);
    chk("rst_x", 48'(ax), 48'h100);
    chk("rst_y", 48'(ay), 48'h100);
    chk("rst_dv", 48'(dv), 48'd0);
    chk("rst_cfg_done", 48'(cfg), 48'd0);

    // power-up wait and configuration write
    rst = 1'b0;
    measure_pwrup(c);
    chk("pwrup_first_cs_fall_cycle", 48'(c), 48'd100);
    wait_cs_rise(ok);
    chk("cfg_cs_rise_seen", 48'(ok), 48'd1);
    chk("cfg_done_not_before_cs_rise", 48'(cfg), 48'd0);
    chk("cfg_bits", 48'(last_bits), 48'd24);
    chk("cfg_bytes", 48'(last_rx[23:0]), 48'h0A2D02);
    repeat (2) @(negedge clk);
    chk("cfg_done_after_cs_rise", 48'(cfg), 48'd1);
    chk("cfg_lead", 48'(lead), 48'(CLK_DIV));
    chk("cfg_tail", 48'(tail), 48'(CLK_DIV));

    // zero sample
    wait_dv(ok);
    chk("zero_dv_seen", 48'(ok), 48'd1);
    chk("zero_x", 48'(ax), 48'h100);
    chk("zero_y", 48'(ay), 48'h100);
    chk("read_bits", 48'(last_bits), 48'd48);
    chk("read_cmd_addr", 48'(last_rx[47:32]), 48'h0B0E);
    chk("read_dummy_zero", 48'(last_rx[31:0]), 48'h0);
    iv_en = 1'b1;

    // X=+1000, Y=-1000
    resp = {16'h0000, 8'hE8, 8'h03, 8'h18, 8'h0C};
    @(negedge clk);
    chk("dv_one_cycle", 48'(dv), 48'd0);
    wait_dv(ok);
    chk("pos1000_dv_seen", 48'(ok), 48'd1);
    chk("x_pos1000", 48'(ax), 48'h17D);
    chk("y_neg1000", 48'(ay), 48'h083);

    // Y high nibble garbage ignored
    resp = {16'h0000, 8'hE8, 8'h03, 8'h18, 8'hFC};
    wait_dv(ok);
    chk("hinib_dv_seen", 48'(ok), 48'd1);
    chk("x_pos1000_again", 48'(ax), 48'h17D);
    chk("y_hinib_ignored", 48'(ay), 48'h083);

    // full-scale extremes
    resp = {16'h0000, 8'hFF, 8'h07, 8'h00, 8'h08};
    wait_dv(ok);
    chk("fs_dv_seen", 48'(ok), 48'd1);
    chk("x_max", 48'(ax), 48'h1FF);
    chk("y_min", 48'(ay), 48'h000);

    // a few more back-to-back reads under overrun
    repeat (3) wait_dv(ok);
    chk("overrun_dv_seen", 48'(ok), 48'd1);
    chk("dv_interval_min", 48'(iv_min >= 2*CLK_DIV + 96*CLK_DIV), 48'd1);
    chk("dv_interval_max", 48'(iv_max <= 2*CLK_DIV + 96*CLK_DIV + 10), 48'd1);
    chk("read_lead", 48'(lead), 48'(CLK_DIV));
    chk("read_tail", 48'(tail), 48'(CLK_DIV));
    chk("cs_high_gap", 48'(min_gap >= CLK_DIV), 48'd1);
    chk("mosi_stable_sclk_high", 48'(mosi_viol), 48'd0);
    chk("no_double_dv", 48'(dv_double), 48'd0);
    chk("outputs_change_only_with_dv", 48'(chg_viol), 48'd0);
    chk("one_read_per_update", 48'(pair_err), 48'd0);
    iv_en = 1'b0;

    // reset at bit 20 of a read
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0 && m_bits == 20 && last_bits == 48) ok = 1'b1;
    end
    chk("bit20_reached", 48'(ok), 48'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cs_n", 48'(cs_n), 48'd1);
    chk("midrst_sclk", 48'(sclk), 48'd0);
    chk("midrst_x", 48'(ax), 48'h100);
    chk("midrst_y", 48'(ay), 48'h100);
    chk("midrst_cfg_done", 48'(cfg), 48'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    measure_pwrup(c);
    chk("repwrup_first_cs_fall_cycle", 48'(c), 48'd100);
    wait_cs_rise(ok);
    chk("recfg_cs_rise_seen", 48'(ok), 48'd1);
    chk("recfg_bits", 48'(last_bits), 48'd24);
    chk("recfg_bytes", 48'(last_rx[23:0]), 48'h0A2D02);
    repeat (2) @(negedge clk);
    chk("recfg_done", 48'(cfg), 48'd1);
    chk("recfg_outputs_zero_g", 48'({ax, ay}), 48'h20100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
